ref_mem_bank_array: RTL
=======================

Name: ref_mem_bank_array

Overview:
- Reference-frame search-window storage: 32 single-port-per-direction RAM banks driven by the reference memory controller's Bank_sel / write_address_all / rd_address_all / rd8R_en / rdR_sel outputs.
- Responder end of that interface: accepts 4-bank-wide write bursts during data preparation and returns all 32 bank words per read for the PE array, with a selectable bank rotation.
- Sits between the external reference-pixel feeder (write data) and the PE array (read data).

Parameters:
- BANKS, 32, number of RAM banks; fixed at 32 to match the 32-bit Bank_sel.
- DEPTH, 128, words per bank.
- ADDR_W, 7, per-bank address width (log2 DEPTH).
- BANK_W, 32, bits per bank word (4 pixels x 8 bit).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- Bank_sel  in  BANKS  per-bank write enable; bit i high writes bank i.
- write_address_all  in  BANKS*ADDR_W  bank i write address at bits [ADDR_W*i +: ADDR_W].
- wr_data  in  4*BANK_W  write data lanes 0..3; lane k at bits [BANK_W*k +: BANK_W].
- rd_address_all  in  BANKS*ADDR_W  bank i read address at bits [ADDR_W*i +: ADDR_W].
- rd8R_en  in  1  read request, active-low (0 = read this cycle).
- rdR_sel  in  4  read rotation select, captured with the read request.
- rd_data  out  BANKS*BANK_W  output lane j at bits [BANK_W*j +: BANK_W].
- rd_valid  out  1  rd_data updated this cycle.
- sel_err  out  1  sticky flag: illegal Bank_sel pattern seen.

Behaviour:
- Reset (rst=1 at a clk edge): rd_data=0, rd_valid=0, sel_err=0, read pipeline cleared. RAM contents are not reset (undefined until written). Reset mid-read drops any in-flight read; rd_valid stays 0 the following cycle.
- Write:
  - Every cycle, for each i with Bank_sel[i]=1, write wr_data lane (i mod 4) into bank i at address write_address_all[ADDR_W*i +: ADDR_W].
  - Bank_sel=0 means no write. No write latency; data is readable by a read issued the next cycle.
- sel_err: set when Bank_sel is nonzero and is not one of the 8 nibble-aligned patterns 0xF<<(4g), g=0..7. Once set, it holds until rst. The writes of that cycle are still performed per bit.
- Read pipeline, 2-cycle latency:
  - Stage 1, edge after rd8R_en=0: capture all 32 bank words mem[i][rd_address_all[ADDR_W*i +: ADDR_W]], register rdR_sel, set s1_valid.
  - Stage 2, next edge: rd_data lane j = stage-1 word of bank (j + 2*rdR_sel) mod 32; rd_valid=1 for exactly one cycle per request.
  - Back-to-back requests on consecutive cycles give rd_valid high on consecutive cycles (full throughput).
  - With rd8R_en=1, rd_valid=0 and rd_data holds its last value.
- Read/write collision (same bank, same address, same cycle): read-first; the read returns the old word.
- Rotation: offset 2*rdR_sel wraps modulo 32; rdR_sel=0 is identity, rdR_sel=15 gives lane j = bank (j+30) mod 32.
- No handshake back-pressure: inputs are sampled every cycle unconditionally.

Test Plan:
- Preparation fill: write 768 cycles, group g = cycle/96, Bank_sel=0xF<<(4g), address = cycle mod 96, wr_data lane k = {g,k,addr} pattern; then read addresses 0..3 with rdR_sel=0 -> each lane j returns {j/4, j%4, addr}, 2 cycles after its request, sel_err=0.
- Rotation: after the fill, read address 5 with rdR_sel=3 -> lane 0 = bank 6 word, lane 31 = bank 5 word; rdR_sel=15 -> lane 0 = bank 30 word.
- Collision: bank 0 address 10 holds 0xAAAAAAAA; in the same cycle write 0x55555555 there and read it -> rd_data lane 0 = 0xAAAAAAAA; a read on the next cycle returns 0x55555555.
- Throughput and idle: rd8R_en low for 4 consecutive cycles then high -> rd_valid high for exactly 4 cycles starting 2 cycles later, after which rd_data holds its final value.
- Illegal select: Bank_sel=0x00000018 -> banks 3 and 4 written with lanes 3 and 0, sel_err rises next cycle and stays 1 until rst.
- Reset mid-read: rd8R_en=0, then rst=1 the next cycle -> rd_valid never asserts for that request; rd_data=0, sel_err=0.

Source files
------------

// File: rtl/ref_mem_bank_array_if.sv
// Reference-memory controller <-> bank array bus: write bursts, per-bank read addresses, rotated read data.
// Latency: none (wires only); the bank array adds 2 cycles from read request to rd_data.
// Backpressure: none; the responder samples every input every cycle.
// Ports: master = reference memory controller / feeder, slave = ref_mem_bank_array.
interface ref_mem_bank_array_if #(
    parameter int BANKS  = 32,
    parameter int ADDR_W = 7,
    parameter int BANK_W = 32
);
    logic [BANKS-1:0]        Bank_sel;
    logic [BANKS*ADDR_W-1:0] write_address_all;
    logic [4*BANK_W-1:0]     wr_data;
    logic [BANKS*ADDR_W-1:0] rd_address_all;
    logic                    rd8R_en;
    logic [3:0]              rdR_sel;
    logic [BANKS*BANK_W-1:0] rd_data;
    logic                    rd_valid;
    logic                    sel_err;

    modport master (
        output Bank_sel, write_address_all, wr_data, rd_address_all, rd8R_en, rdR_sel,
        input  rd_data, rd_valid, sel_err
    );

    modport slave (
        input  Bank_sel, write_address_all, wr_data, rd_address_all, rd8R_en, rdR_sel,
        output rd_data, rd_valid, sel_err
    );
endinterface

// File: rtl/ref_mem_bank_array.sv
// Search-window storage: 32 RAM banks, 4-lane write bursts, 32-word rotated reads for the PE array.
// Latency: writes take effect at the clock edge; reads return 2 cycles after rd8R_en is sampled low.
// Backpressure: none; one read per cycle sustained, the consumer must take rd_data when rd_valid is high.
// Ports: clk, rst (sync, active-high), bus (slave modport of ref_mem_bank_array_if).
module ref_mem_bank_array #(
    parameter int BANKS  = 32,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int BANK_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ref_mem_bank_array_if.slave   bus
);
    localparam int SEL_W  = $clog2(BANKS);
    localparam int GROUPS = BANKS / 4;

    // Stage-1 words from every bank, flattened bank-major.
    logic [BANKS*BANK_W-1:0] s1_flat;
    logic                    s1_valid;
    logic [3:0]              s1_sel;

    logic [BANKS*BANK_W-1:0] rot_data;
    logic [BANKS*BANK_W-1:0] rd_data_q;
    logic                    rd_valid_q;
    logic                    sel_err_q;
    logic                    sel_legal;
    logic                    rd_req;

    // rd8R_en is active-low.
    assign rd_req = ~bus.rd8R_en;

    // Each bank owns its storage and its stage-1 capture register. The read
    // samples mem before this edge's write lands, which gives read-first
    // behaviour on a same-address collision.
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [BANK_W-1:0] mem [DEPTH];
        logic [BANK_W-1:0] s1_word;
        logic [ADDR_W-1:0] waddr;
        logic [ADDR_W-1:0] raddr;

        assign waddr = bus.write_address_all[ADDR_W*b +: ADDR_W];
        assign raddr = bus.rd_address_all[ADDR_W*b +: ADDR_W];

        // Bank b always takes write lane b mod 4.
        always_ff @(posedge clk) begin
            if (bus.Bank_sel[b]) begin
                mem[waddr] <= bus.wr_data[BANK_W*(b%4) +: BANK_W];
            end
        end

        // Data path register is not reset; s1_valid qualifies it.
        always_ff @(posedge clk) begin
            if (rd_req) begin
                s1_word <= mem[raddr];
            end
        end

        assign s1_flat[BANK_W*b +: BANK_W] = s1_word;
    end

    // Output lane j takes bank (j + 2*sel) mod BANKS; the SEL_W-bit sum wraps
    // naturally, so no explicit modulo is needed.
    always_comb begin
        logic [SEL_W-1:0] src;
        rot_data = '0;
        src      = '0;
        for (int j = 0; j < BANKS; j++) begin
            src = SEL_W'(j) + SEL_W'({s1_sel, 1'b0});
            rot_data[BANK_W*j +: BANK_W] = s1_flat[BANK_W*src +: BANK_W];
        end
    end

    // Legal selects are "no write" or one whole nibble-aligned group of 4 banks.
    always_comb begin
        sel_legal = (bus.Bank_sel == '0);
        for (int g = 0; g < GROUPS; g++) begin
            if (bus.Bank_sel == (BANKS'(4'hF) << (4*g))) begin
                sel_legal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sel     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            s1_valid <= rd_req;
            if (rd_req) begin
                s1_sel <= bus.rdR_sel;
            end
            rd_valid_q <= s1_valid;
            // rd_data holds its last value between reads.
            if (s1_valid) begin
                rd_data_q <= rot_data;
            end
            if (!sel_legal) begin
                sel_err_q <= 1'b1;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.sel_err  = sel_err_q;
endmodule
